// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: RV32I opcodes and immediate format codes shared by decode and control
package imm_gen_pkg;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I format classification and sign-extended immediate
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            unk
);
   logic [6:0]  op;
   logic        is_i, is_s, is_b, is_u, is_j, is_r;
   logic [31:0] i32;
   assign op = instr[6:0];
   // classify the opcode, assemble the 32-bit immediate, then sign-extend from bit 31
   always_comb begin
      is_i = op == OP_IMM || op == OP_LOAD || op == OP_JALR;
      is_s = op == OP_STORE;
      is_b = op == OP_BRANCH;
      is_u = op == OP_LUI || op == OP_AUIPC;
      is_j = op == OP_JAL;
      is_r = op == OP_REG;
      i32 = is_i ? {{20{instr[31]}}, instr[31:20]} :
            is_s ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            is_b ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            is_u ? {instr[31:12], 12'b0} :
            is_j ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
      fmt = is_i ? FMT_I : is_s ? FMT_S : is_b ? FMT_B : is_u ? FMT_U : is_j ? FMT_J : FMT_R;
      unk = !(is_i || is_s || is_b || is_u || is_j || is_r);
      imm = XLEN'($signed(i32));
   end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready, 2-entry skid and flush
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       fmt_o,
   output logic             unk_o,
   output logic [TAG_W-1:0] tag_o
);
   localparam int EW = XLEN + 4 + TAG_W;
   logic [XLEN-1:0] d_imm;
   logic [2:0]      d_fmt;
   logic            d_unk;
   logic [EW-1:0]   dec_e, out_e, skd_e;
   logic            out_v, skd_v, rdy;
   logic            acc, drain, ld_dec, ld_skd, mv_skd, out_v_n, skd_v_n;
   imm_decode #(.XLEN(XLEN)) u_dec (
      .instr(instr_i),
      .imm  (d_imm),
      .fmt  (d_fmt),
      .unk  (d_unk)
   );
   assign dec_e = {d_imm, d_fmt, d_unk, tag_i};
   assign {imm_o, fmt_o, unk_o, tag_o} = out_e;
   assign out_valid_o = out_v;
   assign in_ready_o = rdy;
   assign acc = in_valid_i && rdy;
   assign drain = out_v && out_ready_i;
   // route the accepted entry to output or skid; flush overrides everything
   always_comb begin
      ld_dec  = !flush_i && acc && (!out_v || drain);
      ld_skd  = !flush_i && acc && out_v && !drain;
      mv_skd  = !flush_i && skd_v && drain;
      out_v_n = flush_i ? 1'b0 : (ld_dec || mv_skd) ? 1'b1 : drain ? 1'b0 : out_v;
      skd_v_n = flush_i ? 1'b0 : ld_skd ? 1'b1 : mv_skd ? 1'b0 : skd_v;
   end
   // state and data registers; ready is registered as the inverse of next skid occupancy
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_v <= 1'b0;
         skd_v <= 1'b0;
         rdy   <= 1'b1;
         out_e <= '0;
         skd_e <= '0;
      end else begin
         out_v <= out_v_n;
         skd_v <= skd_v_n;
         rdy   <= !skd_v_n;
         if (ld_dec) out_e <= dec_e;
         else if (mv_skd) out_e <= skd_e;
         if (ld_skd) skd_e <= dec_e;
      end
   end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, flow-controlled immediate generator for the decode stage. Takes one 32-bit RV32I instruction per cycle with a tag and classifies its format (R/I/S/B/U/J). Produces the fully sign-extended, byte-aligned immediate at XLEN width. Sits between fetch/IF-ID and the ID-EX register, with a valid/ready handshake on both sides, a 2-entry skid buffer and a synchronous flush for branch redirects.

Parameters:
XLEN, 32, width of imm_o; legal values >= 32
TAG_W, 5, width of the pass-through tag (PC index / ROB tag)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous kill of all held entries
in_valid_i  in  1  instruction present
in_ready_o  out  1  block can accept
instr_i  in  32  raw instruction
tag_i  in  TAG_W  sideband, passed through unchanged
out_valid_o  out  1  result present
out_ready_i  in  1  consumer accepts
imm_o  out  XLEN  sign-extended immediate
fmt_o  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
unk_o  out  1  opcode not recognised
tag_o  out  TAG_W  tag of the presented result

Behaviour:
- Reset (rst_i low, async): out_valid_o=0, skid valid=0, in_ready_o=1, imm_o=0, fmt_o=0, unk_o=0, tag_o=0. Reset mid-transfer drops all entries.
- Opcode decode:
  - 0010011, 0000011, 1100111 -> I: sext(instr[31:20])
  - 0100011 -> S: sext({instr[31:25],instr[11:7]})
  - 1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 0110111, 0010111 -> U: sext({instr[31:12],12'b0})
  - 1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 0110011 -> R: imm=0, unk=0
  - anything else: imm=0, fmt=R, unk=1
- Sign extension always from instr[31] to XLEN. The decode is a pure function of instr_i and is computed before registering.
- Handshake:
  - Input transfer when in_valid_i && in_ready_o.
  - Output transfer when out_valid_o && out_ready_i.
  - in_ready_o is registered and equals !skid_valid, so it has no combinational path from out_ready_i.
- Latency: 1 cycle. Data accepted at edge N is on the outputs after edge N, provided the output register is empty or draining.
- Entry routing:
  - Output register empty or draining this cycle: the accepted entry loads the output register.
  - Output register full and stalled: the accepted entry loads the skid register and in_ready_o drops next cycle.
  - Output transfer while skid valid: skid moves to the output register and skid clears. A simultaneous new input is impossible because in_ready_o=0.
- Outputs are stable while out_valid_o && !out_ready_i.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.
- flush_i has priority over all other events. Next cycle out_valid_o=0, skid cleared, in_ready_o=1. An input accepted in the flush cycle is discarded. imm_o, fmt_o and tag_o hold their stale values (don't-care while invalid).
- Throughput: 1 instruction/cycle with out_ready_i held high.

Decomposition:
- Shared package imm_gen_pkg: opcode localparams (OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG) and the fmt_o encoding constants. The package is reused by the control unit.
- Sub-module imm_decode: combinational, instr -> {imm[XLEN-1:0], fmt, unk}. imm_gen_pipe instantiates it once and adds the output and skid registers plus control.

Test Plan:
1. 0xFFF00093 (addi x1,x0,-1), out_ready_i=1 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, unk_o=0.
2. Back-to-back stream 0xFE112E23 (sw -4), 0xFE000CE3 (beq -8), 0x123450B7 (lui), 0x001000EF (jal +0x800) -> imm_o in order 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000, 0x00000800; fmt_o 2, 3, 4, 5; one result per cycle.
3. out_ready_i=0, drive three valid instrs with tags 1, 2, 3:
   - tag1 is held in the output register, tag2 goes to skid, in_ready_o=0, tag3 is not accepted.
   - Raise out_ready_i: tags emerge 1, 2, 3 with no gaps after release and no loss.
4. Opcode 0x7F instr 0x0000007F -> unk_o=1, imm_o=0, fmt_o=0. Opcode 0110011 (0x002081B3) -> unk_o=0, fmt_o=0.
5. With output and skid both full, assert flush_i together with an input -> next cycle out_valid_o=0, in_ready_o=1. A later instruction emerges alone with the correct imm.
6. Pull rst_i low asynchronously between edges while full -> out_valid_o=0 and in_ready_o=1 immediately. Repeat with XLEN=64: 0xFFF00093 -> imm_o=0xFFFFFFFFFFFFFFFF.
